// File: rtl/net_pkg.sv
// -----------------------------------------------------------------------------
// net_pkg
// Shared definitions for the mesh node interface: packet field positions and
// widths, the packed packet layout, a packet builder and a saturating counter
// increment helper.
//
// Packet layout (64 bits):
//   [63:61] dest_x  [60:58] dest_y  [57:55] src_x  [54:52] src_y
//   [51:36] timestamp               [35:0]  payload
// -----------------------------------------------------------------------------
package net_pkg;

  localparam int PKT_W       = 64;
  localparam int COORD_W     = 3;
  localparam int TS_W        = 16;
  localparam int PAYLOAD_W   = 36;
  localparam int CNT_W       = 32;

  localparam int DEST_X_LSB  = 61;
  localparam int DEST_Y_LSB  = 58;
  localparam int SRC_X_LSB   = 55;
  localparam int SRC_Y_LSB   = 52;
  localparam int TS_LSB      = 36;
  localparam int PAYLOAD_LSB = 0;

  // Field order matches the bit layout above, MSB first.
  typedef struct packed {
    logic [COORD_W-1:0]   dest_x;
    logic [COORD_W-1:0]   dest_y;
    logic [COORD_W-1:0]   src_x;
    logic [COORD_W-1:0]   src_y;
    logic [TS_W-1:0]      timestamp;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  function automatic packet_t build_packet(
    input logic [COORD_W-1:0]   dest_x,
    input logic [COORD_W-1:0]   dest_y,
    input logic [COORD_W-1:0]   src_x,
    input logic [COORD_W-1:0]   src_y,
    input logic [TS_W-1:0]      timestamp,
    input logic [PAYLOAD_W-1:0] payload
  );
    packet_t pkt;
    pkt.dest_x    = dest_x;
    pkt.dest_y    = dest_y;
    pkt.src_x     = src_x;
    pkt.src_y     = src_y;
    pkt.timestamp = timestamp;
    pkt.payload   = payload;
    return pkt;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/node_fifo.sv
// -----------------------------------------------------------------------------
// node_fifo
// Synchronous FIFO with combinational head read. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop from an empty FIFO
// is ignored.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_push / i_data    write strobe and data
//   i_pop              consume the head entry
//   o_data             head entry (stale contents when empty)
//   o_full / o_empty   status flags from the registered occupancy
//   o_count            registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module node_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // and count define validity, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mesh_node_interface.sv
// -----------------------------------------------------------------------------
// mesh_node_interface
// Network interface between a local source/sink and router local port 4.
//
// Injection: source packets are stamped with this node's coordinates and the
// current cycle count, queued, and written to the router whenever the queue is
// non-empty and the router is not holding. Packets with an out-of-mesh
// destination are accepted and discarded (bad_dest_error).
//
// Ejection: router deliveries are queued; hold is raised toward the router
// once occupancy reaches EJ_DEPTH-HOLD_SLACK. Deliveries into a full queue
// without a simultaneous sink pop are dropped (overflow_error). The queue
// stores latency in place of the timestamp. Popping a packet addressed to a
// different node sets misroute_error but still delivers it.
//
// Ports:
//   clk, reset                           clock, synchronous active-high reset
//   src_valid/src_ready/src_dest_*/src_payload   local source handshake
//   nodeToNetworkData/WriteRequest       packet toward the router
//   networkToNodeHoldRequest             router stall
//   networkToNodeData/WriteRequest       packet from the router
//   nodeToNetworkHoldRequest             stall toward the router
//   sink_valid/sink_ready/sink_*         local sink handshake and fields
//   pkt_sent_count / pkt_recv_count      saturating packet counters
//   misroute/overflow/bad_dest_error     sticky error flags
// -----------------------------------------------------------------------------
module mesh_node_interface
  import net_pkg::*;
#(
  parameter int X_LOC      = 0,
  parameter int Y_LOC      = 0,
  parameter int X_NODES    = 3,
  parameter int Y_NODES    = 3,
  parameter int FIFO_WIDTH = 64,
  parameter int INJ_DEPTH  = 4,
  parameter int EJ_DEPTH   = 4,
  parameter int HOLD_SLACK = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [2:0]            src_dest_x,
  input  logic [2:0]            src_dest_y,
  input  logic [35:0]           src_payload,
  output logic [FIFO_WIDTH-1:0] nodeToNetworkData,
  output logic                  nodeToNetworkWriteRequest,
  input  logic                  networkToNodeHoldRequest,
  input  logic [FIFO_WIDTH-1:0] networkToNodeData,
  input  logic                  networkToNodeWriteRequest,
  output logic                  nodeToNetworkHoldRequest,
  output logic                  sink_valid,
  input  logic                  sink_ready,
  output logic [2:0]            sink_src_x,
  output logic [2:0]            sink_src_y,
  output logic [35:0]           sink_payload,
  output logic [15:0]           sink_latency,
  output logic [31:0]           pkt_sent_count,
  output logic [31:0]           pkt_recv_count,
  output logic                  misroute_error,
  output logic                  overflow_error,
  output logic                  bad_dest_error
);

  localparam logic [COORD_W-1:0] L_X   = COORD_W'(X_LOC);
  localparam logic [COORD_W-1:0] L_Y   = COORD_W'(Y_LOC);
  localparam int                 EJ_CW = $clog2(EJ_DEPTH) + 1;

  logic [TS_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0] r_sent_count;
  logic [CNT_W-1:0] r_recv_count;
  logic             r_misroute;
  logic             r_overflow;
  logic             r_bad_dest;

  // Injection side
  logic                          w_src_fire;
  logic                          w_dest_ok;
  logic                          w_inj_push;
  packet_t                       w_inj_pkt;
  packet_t                       w_inj_head;
  logic                          w_inj_full;
  logic                          w_inj_empty;
  logic [$clog2(INJ_DEPTH):0]    w_inj_count_unused;

  // Ejection side
  packet_t                       w_net_pkt;
  packet_t                       w_ej_in;
  packet_t                       w_ej_head;
  packet_t                       w_sink_pkt;
  logic                          w_ej_push;
  logic                          w_ej_drop;
  logic                          w_ej_full;
  logic                          w_ej_empty;
  logic [EJ_CW-1:0]              w_ej_count;
  logic                          w_sink_pop;
  logic                          w_misrouted;

  // ---------------------------------------------------------------------------
  // Injection
  // ---------------------------------------------------------------------------
  // Held low during reset so the source never sees a stale ready.
  assign src_ready  = !w_inj_full && !reset;
  assign w_src_fire = src_valid && src_ready;
  assign w_dest_ok  = ({1'b0, src_dest_x} < 4'(X_NODES)) &&
                      ({1'b0, src_dest_y} < 4'(Y_NODES));
  assign w_inj_push = w_src_fire && w_dest_ok;
  assign w_inj_pkt  = build_packet(src_dest_x, src_dest_y, L_X, L_Y,
                                   r_cycle_cnt, src_payload);

  node_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_inj_push),
    .i_pop   (nodeToNetworkWriteRequest),
    .i_data  (w_inj_pkt),
    .o_data  (w_inj_head),
    .o_full  (w_inj_full),
    .o_empty (w_inj_empty),
    .o_count (w_inj_count_unused)
  );

  assign nodeToNetworkWriteRequest = !w_inj_empty && !networkToNodeHoldRequest;
  assign nodeToNetworkData         = w_inj_empty ? '0 : w_inj_head;

  // ---------------------------------------------------------------------------
  // Ejection
  // ---------------------------------------------------------------------------
  assign w_net_pkt  = packet_t'(networkToNodeData);
  assign w_sink_pop = sink_valid && sink_ready;
  // A full queue still takes a delivery when the sink frees a slot this cycle.
  assign w_ej_push  = networkToNodeWriteRequest && (!w_ej_full || w_sink_pop);
  assign w_ej_drop  = networkToNodeWriteRequest && w_ej_full && !w_sink_pop;

  // NOTE: combinational blocks assign a full default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ej_in           = w_net_pkt;
    // Latency replaces the timestamp; modular subtraction handles wrap.
    w_ej_in.timestamp = r_cycle_cnt - w_net_pkt.timestamp;
  end

  node_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_ej_push),
    .i_pop   (w_sink_pop),
    .i_data  (w_ej_in),
    .o_data  (w_ej_head),
    .o_full  (w_ej_full),
    .o_empty (w_ej_empty),
    .o_count (w_ej_count)
  );

  assign nodeToNetworkHoldRequest = (w_ej_count >= EJ_CW'(EJ_DEPTH - HOLD_SLACK));

  // Sink fields read as zero while the queue is empty.
  always_comb begin
    w_sink_pkt = '0;
    if (!w_ej_empty) w_sink_pkt = w_ej_head;
  end

  assign sink_valid   = !w_ej_empty;
  assign sink_src_x   = w_sink_pkt.src_x;
  assign sink_src_y   = w_sink_pkt.src_y;
  assign sink_payload = w_sink_pkt.payload;
  assign sink_latency = w_sink_pkt.timestamp;
  assign w_misrouted  = (w_sink_pkt.dest_x != L_X) || (w_sink_pkt.dest_y != L_Y);

  // ---------------------------------------------------------------------------
  // Cycle counter, statistics and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt  <= '0;
      r_sent_count <= '0;
      r_recv_count <= '0;
      r_misroute   <= 1'b0;
      r_overflow   <= 1'b0;
      r_bad_dest   <= 1'b0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (nodeToNetworkWriteRequest) r_sent_count <= sat_inc(r_sent_count);
      if (w_sink_pop)                r_recv_count <= sat_inc(r_recv_count);
      if (w_sink_pop && w_misrouted) r_misroute   <= 1'b1;
      if (w_ej_drop)                 r_overflow   <= 1'b1;
      if (w_src_fire && !w_dest_ok)  r_bad_dest   <= 1'b1;
    end
  end

  assign pkt_sent_count = r_sent_count;
  assign pkt_recv_count = r_recv_count;
  assign misroute_error = r_misroute;
  assign overflow_error = r_overflow;
  assign bad_dest_error = r_bad_dest;

endmodule

// File: tb/tb_mesh_node_interface.sv
// -----------------------------------------------------------------------------
// tb_mesh_node_interface
// Self-checking bench for mesh_node_interface placed at node (1,1) of a 3x3
// mesh. Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. A per-cycle vector table covers the injection hold/release
// burst and the ejection fill/overflow/drain; hand-written sequences cover
// reset, latency wrap, misrouting, bad destinations, reset mid-burst and a
// delivery into a full queue with a simultaneous sink pop.
// -----------------------------------------------------------------------------
module tb_mesh_node_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        src_valid;
  logic        src_ready;
  logic [2:0]  src_dest_x;
  logic [2:0]  src_dest_y;
  logic [35:0] src_payload;
  logic [63:0] n2n_data;
  logic        n2n_wr;
  logic        net_hold;
  logic [63:0] net_data;
  logic        net_wr;
  logic        node_hold;
  logic        sink_valid;
  logic        sink_ready;
  logic [2:0]  sink_src_x;
  logic [2:0]  sink_src_y;
  logic [35:0] sink_payload;
  logic [15:0] sink_latency;
  logic [31:0] pkt_sent_count;
  logic [31:0] pkt_recv_count;
  logic        misroute_error;
  logic        overflow_error;
  logic        bad_dest_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mesh_node_interface #(
    .X_LOC      (1),
    .Y_LOC      (1),
    .X_NODES    (3),
    .Y_NODES    (3),
    .FIFO_WIDTH (64),
    .INJ_DEPTH  (4),
    .EJ_DEPTH   (4),
    .HOLD_SLACK (1)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .src_valid                 (src_valid),
    .src_ready                 (src_ready),
    .src_dest_x                (src_dest_x),
    .src_dest_y                (src_dest_y),
    .src_payload               (src_payload),
    .nodeToNetworkData         (n2n_data),
    .nodeToNetworkWriteRequest (n2n_wr),
    .networkToNodeHoldRequest  (net_hold),
    .networkToNodeData         (net_data),
    .networkToNodeWriteRequest (net_wr),
    .nodeToNetworkHoldRequest  (node_hold),
    .sink_valid                (sink_valid),
    .sink_ready                (sink_ready),
    .sink_src_x                (sink_src_x),
    .sink_src_y                (sink_src_y),
    .sink_payload              (sink_payload),
    .sink_latency              (sink_latency),
    .pkt_sent_count            (pkt_sent_count),
    .pkt_recv_count            (pkt_recv_count),
    .misroute_error            (misroute_error),
    .overflow_error            (overflow_error),
    .bad_dest_error            (bad_dest_error)
  );

  // Reference cycle counter: 0 in the first cycle after reset, wraps at 2^16.
  logic [15:0] m_cyc;
  always @(posedge clk) begin
    if (reset) m_cyc <= 16'd0;
    else       m_cyc <= m_cyc + 16'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  function automatic logic [63:0] mk(input logic [2:0] dx, input logic [2:0] dy,
                                     input logic [2:0] sx, input logic [2:0] sy,
                                     input logic [15:0] ts, input logic [35:0] pay);
    return {dx, dy, sx, sy, ts, pay};
  endfunction

  task automatic clear_inputs();
    src_valid   = 1'b0;
    src_dest_x  = 3'd0;
    src_dest_y  = 3'd0;
    src_payload = 36'd0;
    net_hold    = 1'b0;
    net_data    = 64'd0;
    net_wr      = 1'b0;
    sink_ready  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    to_pos();
    to_pos();
    reset = 1'b0;
  endtask

  // One table row = one clock cycle: inputs plus expected outputs at the
  // falling edge of that cycle.
  typedef struct {
    logic        sv;
    logic [2:0]  dx;
    logic [2:0]  dy;
    logic [35:0] pay;
    logic        hold;
    logic        nwr;
    logic [63:0] ndata;
    logic        skr;
    logic        e_rdy;
    logic        e_wr;
    logic [35:0] e_npay;
    logic        e_hold;
    logic        e_skv;
    logic [35:0] e_skpay;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic sv, input logic [2:0] dx, input logic [2:0] dy,
                             input logic [35:0] pay, input logic hold, input logic nwr,
                             input logic [63:0] ndata, input logic skr,
                             input logic e_rdy, input logic e_wr, input logic [35:0] e_npay,
                             input logic e_hold, input logic e_skv, input logic [35:0] e_skpay);
    vec_t r;
    r.sv = sv; r.dx = dx; r.dy = dy; r.pay = pay; r.hold = hold;
    r.nwr = nwr; r.ndata = ndata; r.skr = skr;
    r.e_rdy = e_rdy; r.e_wr = e_wr; r.e_npay = e_npay;
    r.e_hold = e_hold; r.e_skv = e_skv; r.e_skpay = e_skpay;
    return r;
  endfunction

  logic [15:0] c0;

  initial begin
    // ---- vector table --------------------------------------------------------
    // Injection under hold: 4 pushes fill the queue, release drains in order.
    vecs.push_back(v(1, 0, 0, 36'h11, 1, 0, 64'd0, 0,  1, 0, 36'h00,  0, 0, 36'h0));
    vecs.push_back(v(1, 0, 0, 36'h12, 1, 0, 64'd0, 0,  1, 0, 36'h11,  0, 0, 36'h0));
    vecs.push_back(v(1, 0, 0, 36'h13, 1, 0, 64'd0, 0,  1, 0, 36'h11,  0, 0, 36'h0));
    vecs.push_back(v(1, 0, 0, 36'h14, 1, 0, 64'd0, 0,  1, 0, 36'h11,  0, 0, 36'h0));
    vecs.push_back(v(0, 0, 0, 36'h00, 1, 0, 64'd0, 0,  0, 0, 36'h11,  0, 0, 36'h0));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 0,  0, 1, 36'h11,  0, 0, 36'h0));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 0,  1, 1, 36'h12,  0, 0, 36'h0));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 0,  1, 1, 36'h13,  0, 0, 36'h0));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 0,  1, 1, 36'h14,  0, 0, 36'h0));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 0,  1, 0, 36'h00,  0, 0, 36'h0));
    // Ejection with sink stalled: hold at occupancy 3, 4th accepted, 5th dropped.
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 1, mk(1,1,0,0,16'd0,36'h21), 0,  1, 0, 36'h0,  0, 0, 36'h00));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 1, mk(1,1,0,0,16'd0,36'h22), 0,  1, 0, 36'h0,  0, 1, 36'h21));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 1, mk(1,1,0,0,16'd0,36'h23), 0,  1, 0, 36'h0,  0, 1, 36'h21));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 1, mk(1,1,0,0,16'd0,36'h24), 0,  1, 0, 36'h0,  1, 1, 36'h21));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 1, mk(1,1,0,0,16'd0,36'h25), 0,  1, 0, 36'h0,  1, 1, 36'h21));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0,                    0,  1, 0, 36'h0,  1, 1, 36'h21));
    // Drain in order; hold drops once occupancy falls below 3.
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 1,  1, 0, 36'h0,  1, 1, 36'h21));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 1,  1, 0, 36'h0,  1, 1, 36'h22));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 1,  1, 0, 36'h0,  0, 1, 36'h23));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 1,  1, 0, 36'h0,  0, 1, 36'h24));
    vecs.push_back(v(0, 0, 0, 36'h00, 0, 0, 64'd0, 1,  1, 0, 36'h0,  0, 0, 36'h00));

    // ---- reset state ---------------------------------------------------------
    do_reset();
    to_neg();
    check("rst src_ready",  src_ready, 1);
    check("rst wr_req",     n2n_wr, 0);
    check("rst n2n_data",   n2n_data, 0);
    check("rst hold_out",   node_hold, 0);
    check("rst sink_valid", sink_valid, 0);
    check("rst sink_fields", {sink_src_x, sink_src_y, sink_latency, sink_payload}, 0);
    check("rst counts",     {pkt_sent_count, pkt_recv_count}, 0);
    check("rst flags",      {misroute_error, overflow_error, bad_dest_error}, 0);

    // ---- single injection: dest (2,1), payload 5 ----------------------------
    to_pos();
    src_valid = 1'b1; src_dest_x = 3'd2; src_dest_y = 3'd1; src_payload = 36'h5;
    c0 = m_cyc;
    to_neg();
    check("inj0 src_ready", src_ready, 1);
    check("inj0 wr_req same cycle", n2n_wr, 0);
    to_pos();
    src_valid = 1'b0;
    to_neg();
    check("inj0 wr_req +1", n2n_wr, 1);
    check("inj0 hdr[63:52]", n2n_data[63:52], {3'd2, 3'd1, 3'd1, 3'd1});
    check("inj0 packet", n2n_data, mk(3'd2, 3'd1, 3'd1, 3'd1, c0, 36'h5));
    to_pos();
    to_neg();
    check("inj0 wr_req after pop", n2n_wr, 0);
    check("inj0 sent_count", pkt_sent_count, 1);

    // ---- table ---------------------------------------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      to_pos();
      src_valid   = vecs[i].sv;
      src_dest_x  = vecs[i].dx;
      src_dest_y  = vecs[i].dy;
      src_payload = vecs[i].pay;
      net_hold    = vecs[i].hold;
      net_wr      = vecs[i].nwr;
      net_data    = vecs[i].ndata;
      sink_ready  = vecs[i].skr;
      to_neg();
      check($sformatf("v%0d src_ready", i),  src_ready,          vecs[i].e_rdy);
      check($sformatf("v%0d wr_req", i),     n2n_wr,             vecs[i].e_wr);
      check($sformatf("v%0d n2n_payload", i), n2n_data[35:0],    vecs[i].e_npay);
      check($sformatf("v%0d hold_out", i),   node_hold,          vecs[i].e_hold);
      check($sformatf("v%0d sink_valid", i), sink_valid,         vecs[i].e_skv);
      check($sformatf("v%0d sink_payload", i), sink_payload,     vecs[i].e_skpay);
    end
    clear_inputs();
    to_neg();
    check("tbl overflow", overflow_error, 1);
    check("tbl recv_count", pkt_recv_count, 4);
    check("tbl sent_count", pkt_sent_count, 5);
    check("tbl misroute", misroute_error, 0);
    check("tbl bad_dest", bad_dest_error, 0);

    // ---- latency wrap and misroute ------------------------------------------
    do_reset();                 // now in the cycle where cycle_cnt = 0
    repeat (3) to_pos();        // cycle_cnt = 3
    net_wr = 1'b1; net_data = mk(3'd1, 3'd1, 3'd2, 3'd0, 16'hFFFE, 36'h77);
    to_pos();                   // cycle_cnt = 4
    net_data = mk(3'd2, 3'd2, 3'd0, 3'd1, 16'h0000, 36'h88);
    to_pos();
    net_wr = 1'b0; net_data = 64'd0;
    to_neg();
    check("lat sink_valid", sink_valid, 1);
    check("lat latency wrap", sink_latency, 16'd5);
    check("lat payload", sink_payload, 36'h77);
    check("lat src", {sink_src_x, sink_src_y}, {3'd2, 3'd0});
    to_pos();
    sink_ready = 1'b1;
    to_neg();
    check("lat misroute before pop", misroute_error, 0);
    to_pos();
    sink_ready = 1'b0;
    to_neg();
    check("mis payload", sink_payload, 36'h88);
    check("mis latency", sink_latency, 16'd4);
    check("mis src", {sink_src_x, sink_src_y}, {3'd0, 3'd1});
    check("mis flag local pop", misroute_error, 0);
    check("mis recv_count 1", pkt_recv_count, 1);
    to_pos();
    sink_ready = 1'b1;
    to_pos();
    sink_ready = 1'b0;
    to_neg();
    check("mis flag", misroute_error, 1);
    check("mis delivered", sink_valid, 0);
    check("mis recv_count 2", pkt_recv_count, 2);

    // ---- bad destinations and mesh boundary ---------------------------------
    to_pos();
    src_valid = 1'b1; src_dest_x = 3'd5; src_dest_y = 3'd0; src_payload = 36'h99;
    to_neg();
    check("bad src_ready", src_ready, 1);
    to_pos();
    src_valid = 1'b0;
    to_neg();
    check("bad never written", n2n_wr, 0);
    check("bad flag", bad_dest_error, 1);
    to_pos();
    src_valid = 1'b1; src_dest_x = 3'd0; src_dest_y = 3'd3; src_payload = 36'hCD;
    to_pos();
    src_dest_x = 3'd2; src_dest_y = 3'd2; src_payload = 36'hAB;
    to_pos();
    src_valid = 1'b0;
    to_neg();
    check("edge (2,2) written", n2n_wr, 1);
    check("edge y=3 discarded", n2n_data[35:0], 36'hAB);
    to_pos();
    to_neg();
    check("edge sent_count", pkt_sent_count, 1);

    // ---- reset mid-burst -----------------------------------------------------
    net_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      to_pos();
      src_valid = 1'b1; src_dest_x = 3'd0; src_dest_y = 3'd2; src_payload = 36'(k + 'h40);
      net_wr = (k < 2); net_data = mk(3'd1, 3'd1, 3'd0, 3'd0, 16'd0, 36'(k + 'h50));
    end
    to_pos();
    src_valid = 1'b0; net_wr = 1'b0;
    to_neg();
    check("mid pre wr_req held", n2n_wr, 0);
    check("mid pre sink_valid", sink_valid, 1);
    to_pos();
    reset = 1'b1; net_hold = 1'b0;
    to_pos();
    to_neg();
    check("mid rst src_ready", src_ready, 0);
    check("mid rst wr/data", {n2n_wr, n2n_data}, 0);
    check("mid rst sink", {sink_valid, sink_payload, node_hold}, 0);
    check("mid rst counts", {pkt_sent_count, pkt_recv_count}, 0);
    check("mid rst flags", {misroute_error, overflow_error, bad_dest_error}, 0);
    to_pos();
    reset = 1'b0;
    to_neg();
    check("mid post src_ready", src_ready, 1);
    check("mid post inj empty", n2n_wr, 0);
    check("mid post ej empty", sink_valid, 0);

    // ---- delivery into a full queue with a simultaneous sink pop -------------
    for (int k = 0; k < 4; k++) begin
      to_pos();
      net_wr = 1'b1; net_data = mk(3'd1, 3'd1, 3'd2, 3'd2, 16'd0, 36'(k + 'h31));
    end
    to_pos();
    net_data = mk(3'd1, 3'd1, 3'd2, 3'd2, 16'd0, 36'h35);
    sink_ready = 1'b1;
    to_pos();
    net_wr = 1'b0; net_data = 64'd0;
    to_neg();
    check("fullpop no overflow", overflow_error, 0);
    check("fullpop hold", node_hold, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        to_pos();
        to_neg();
      end
      check($sformatf("fullpop drain%0d", k), sink_payload, 36'(k + 'h32));
    end
    to_pos();
    sink_ready = 1'b0;
    to_neg();
    check("fullpop empty", sink_valid, 0);
    check("fullpop recv_count", pkt_recv_count, 5);
    check("fullpop misroute", misroute_error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
